// File: rtl/lda_job_sequencer.sv
// Job sequencer for the line-drawing accelerator: buffers pushed jobs in a small FIFO and
// issues them one at a time to the datapath through a START/RUN/DONE handshake.
module lda_job_sequencer #(
   parameter int JOB_W = 32,
   parameter int DEPTH = 4,
   parameter int CYC_W = 24,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_GO,
   input  logic [JOB_W-1:0]           i_JOB,
   input  logic                       i_ABORT,
   input  logic                       i_CLR_STATUS,
   input  logic                       i_CONDITION,
   output logic                       o_READY,
   output logic                       o_START,
   output logic                       o_RUN,
   output logic                       o_DONE,
   output logic [JOB_W-1:0]           o_JOB,
   output logic                       o_BUSY,
   output logic [$clog2(DEPTH+1)-1:0] o_PENDING,
   output logic [CYC_W-1:0]           o_CYCLES,
   output logic [CNT_W-1:0]           o_JOB_CNT,
   output logic                       o_OVERFLOW,
   output logic                       o_ABORTED
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int PEND_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state;
   logic [JOB_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PEND_W-1:0]  count;
   logic [CYC_W-1:0]   cyc;
   logic               job_aborted;

   logic push;
   logic pop;
   logic ovf_set;
   logic abt_set;

   assign o_READY   = (count != PEND_W'(DEPTH));
   assign o_PENDING = count;
   assign o_BUSY    = (state != S_IDLE) || (count != '0);

   // An abort always flushes the queue, so it also blocks both push and pop.
   assign push    = i_GO && o_READY && !i_ABORT;
   assign pop     = (state == S_IDLE) && (count != '0) && !i_ABORT;
   assign ovf_set = i_GO && !o_READY && !i_ABORT;
   assign abt_set = i_ABORT && ((state == S_LOAD) || (state == S_RUN) || (count != '0));

   // NOTE: payload storage has no reset; occupancy and pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= i_JOB;
   end

   // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         cyc         <= '0;
         job_aborted <= 1'b0;
         o_START     <= 1'b0;
         o_RUN       <= 1'b0;
         o_DONE      <= 1'b0;
         o_JOB       <= '0;
         o_CYCLES    <= '0;
         o_JOB_CNT   <= '0;
         o_OVERFLOW  <= 1'b0;
         o_ABORTED   <= 1'b0;
      end else begin
         o_START <= 1'b0;
         o_RUN   <= 1'b0;
         o_DONE  <= 1'b0;

         if (i_ABORT) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end

         // A set event in the same cycle as a clear takes priority.
         if (ovf_set)           o_OVERFLOW <= 1'b1;
         else if (i_CLR_STATUS) o_OVERFLOW <= 1'b0;
         if (abt_set)           o_ABORTED  <= 1'b1;
         else if (i_CLR_STATUS) o_ABORTED  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  o_JOB       <= mem[rd_ptr];
                  cyc         <= '0;
                  job_aborted <= 1'b0;
                  state       <= S_LOAD;
                  o_START     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (i_ABORT) begin
                  job_aborted <= 1'b1;
                  state       <= S_DONE;
                  o_DONE      <= 1'b1;
               end else begin
                  state <= S_RUN;
                  o_RUN <= 1'b1;
               end
            end
            S_RUN: begin
               if (cyc != '1) cyc <= cyc + 1'b1;
               if (i_ABORT) begin
                  job_aborted <= 1'b1;
                  state       <= S_DONE;
                  o_DONE      <= 1'b1;
               end else if (i_CONDITION) begin
                  state  <= S_DONE;
                  o_DONE <= 1'b1;
               end else begin
                  o_RUN <= 1'b1;
               end
            end
            S_DONE: begin
               o_CYCLES <= cyc;
               if (!job_aborted) o_JOB_CNT <= o_JOB_CNT + 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lda_job_sequencer.sv
// Self-checking bench for lda_job_sequencer: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_lda_job_sequencer;

   localparam int JOB_W   = 32;
   localparam int DEPTH   = 4;
   localparam int CYC_W   = 4;
   localparam int CNT_W   = 4;
   localparam int PEND_W  = $clog2(DEPTH + 1);
   localparam int CYC_MAX = (1 << CYC_W) - 1;
   localparam int CNT_MOD = 1 << CNT_W;

   localparam int PH_IDLE  = 0;
   localparam int PH_START = 1;
   localparam int PH_RUN   = 2;
   localparam int PH_DONE  = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_GO = 1'b0;
   logic [JOB_W-1:0]  i_JOB = '0;
   logic              i_ABORT = 1'b0;
   logic              i_CLR_STATUS = 1'b0;
   logic              i_CONDITION = 1'b0;
   logic              o_READY, o_START, o_RUN, o_DONE, o_BUSY, o_OVERFLOW, o_ABORTED;
   logic [JOB_W-1:0]  o_JOB;
   logic [PEND_W-1:0] o_PENDING;
   logic [CYC_W-1:0]  o_CYCLES;
   logic [CNT_W-1:0]  o_JOB_CNT;

   always #5 clk = ~clk;

   lda_job_sequencer #(
      .JOB_W(JOB_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .i_GO(i_GO), .i_JOB(i_JOB), .i_ABORT(i_ABORT),
      .i_CLR_STATUS(i_CLR_STATUS), .i_CONDITION(i_CONDITION), .o_READY(o_READY),
      .o_START(o_START), .o_RUN(o_RUN), .o_DONE(o_DONE), .o_JOB(o_JOB), .o_BUSY(o_BUSY),
      .o_PENDING(o_PENDING), .o_CYCLES(o_CYCLES), .o_JOB_CNT(o_JOB_CNT),
      .o_OVERFLOW(o_OVERFLOW), .o_ABORTED(o_ABORTED)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: job queue plus the lifecycle phase of the job in flight.
   logic [JOB_W-1:0] m_q[$];
   int               m_phase;
   logic [JOB_W-1:0] m_job;
   int               m_cyc;
   bit               m_job_aborted;
   int               m_cycles;
   int               m_cnt;
   bit               m_ovf;
   bit               m_abt;

   task automatic model_reset();
      m_q.delete();
      m_phase       = PH_IDLE;
      m_job         = '0;
      m_cyc         = 0;
      m_job_aborted = 0;
      m_cycles      = 0;
      m_cnt         = 0;
      m_ovf         = 0;
      m_abt         = 0;
   endtask

   task automatic model_step(input logic go, input logic [JOB_W-1:0] job, input logic abort,
                             input logic clr, input logic cond);
      int sz;
      bit push;
      sz   = m_q.size();
      push = go && (sz < DEPTH) && !abort;
      if (go && (sz == DEPTH) && !abort) m_ovf = 1;
      else if (clr)                      m_ovf = 0;
      if (abort && (m_phase == PH_START || m_phase == PH_RUN || sz != 0)) m_abt = 1;
      else if (clr)                                                        m_abt = 0;
      case (m_phase)
         PH_IDLE: begin
            if (!abort && sz != 0) begin
               m_job         = m_q.pop_front();
               m_cyc         = 0;
               m_job_aborted = 0;
               m_phase       = PH_START;
            end
         end
         PH_START: begin
            if (abort) begin
               m_job_aborted = 1;
               m_phase       = PH_DONE;
            end else begin
               m_phase = PH_RUN;
            end
         end
         PH_RUN: begin
            if (m_cyc < CYC_MAX) m_cyc++;
            if (abort) begin
               m_job_aborted = 1;
               m_phase       = PH_DONE;
            end else if (cond) begin
               m_phase = PH_DONE;
            end
         end
         default: begin
            m_cycles = m_cyc;
            if (!m_job_aborted) m_cnt = (m_cnt + 1) % CNT_MOD;
            m_phase = PH_IDLE;
         end
      endcase
      if (abort) m_q.delete();
      if (push)  m_q.push_back(job);
   endtask

   task automatic check_all();
      check("ready",    64'(o_READY),    64'(m_q.size() < DEPTH));
      check("start",    64'(o_START),    64'(m_phase == PH_START));
      check("run",      64'(o_RUN),      64'(m_phase == PH_RUN));
      check("done",     64'(o_DONE),     64'(m_phase == PH_DONE));
      check("job",      64'(o_JOB),      64'(m_job));
      check("busy",     64'(o_BUSY),     64'(m_phase != PH_IDLE || m_q.size() != 0));
      check("pending",  64'(o_PENDING),  64'(m_q.size()));
      check("cycles",   64'(o_CYCLES),   64'(m_cycles));
      check("job_cnt",  64'(o_JOB_CNT),  64'(m_cnt));
      check("overflow", 64'(o_OVERFLOW), 64'(m_ovf));
      check("aborted",  64'(o_ABORTED),  64'(m_abt));
   endtask

   // Drive one cycle of inputs, advance the model, then compare just after the edge.
   task automatic tick(input logic go, input logic [JOB_W-1:0] job, input logic abort,
                       input logic clr, input logic cond);
      i_GO         = go;
      i_JOB        = job;
      i_ABORT      = abort;
      i_CLR_STATUS = clr;
      i_CONDITION  = cond;
      model_step(go, job, abort, clr, cond);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input logic cond);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, cond);
   endtask

   initial begin
      int saved_cnt;
      model_reset();
      #3;
      check_all();
      #14 reset = 1'b0;
      @(posedge clk);
      #1;
      check_all();

      // Single job: five RUN cycles, CONDITION on the fifth.
      tick(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      check("t1_start", 64'(o_START), 64'd1);
      idle(5, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("t1_done", 64'(o_DONE), 64'd1);
      check("t1_job", 64'(o_JOB), 64'hA5A5_0001);
      idle(1, 1'b0);
      check("t1_cycles", 64'(o_CYCLES), 64'd5);
      check("t1_cnt", 64'(o_JOB_CNT), 64'd1);

      // Fill: five consecutive pushes while idle, all accepted, then drain in order.
      for (int i = 0; i < 5; i++) tick(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0);
      check("t2_no_ovf", 64'(o_OVERFLOW), 64'd0);
      idle(30, 1'b1);
      check("t2_idle", 64'(o_BUSY), 64'd0);

      // Overflow while a job is held in RUN.
      tick(1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b1, 32'hC000_0001 + i, 1'b0, 1'b0, 1'b0);
      check("t3_pending", 64'(o_PENDING), 64'd4);
      check("t3_ready", 64'(o_READY), 64'd0);
      check("t3_ovf", 64'(o_OVERFLOW), 64'd1);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("t3_clr", 64'(o_OVERFLOW), 64'd0);

      // Abort mid-run with jobs pending.
      saved_cnt = int'(o_JOB_CNT);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("t4_done", 64'(o_DONE), 64'd1);
      check("t4_aborted", 64'(o_ABORTED), 64'd1);
      check("t4_pending", 64'(o_PENDING), 64'd0);
      idle(1, 1'b0);
      check("t4_cnt", 64'(o_JOB_CNT), 64'(saved_cnt));
      check("t4_idle", 64'(o_BUSY), 64'd0);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Saturation: 20 RUN cycles on a 4-bit counter.
      tick(1'b1, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(19, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0);
      check("t5_sat", 64'(o_CYCLES), 64'hF);

      // Async reset mid-RUN with queued jobs.
      tick(1'b1, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 32'hE000_0001, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 32'hE000_0002, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("t6_ready", 64'(o_READY), 64'd1);
      #3 reset = 1'b0;
      idle(4, 1'b0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic go, ab, clr, cond;
         go   = ($urandom_range(0, 2) == 0);
         ab   = ($urandom_range(0, 49) == 0);
         clr  = ($urandom_range(0, 19) == 0);
         cond = (i % 400 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
         tick(go, JOB_W'($urandom), ab, clr, cond);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
